seg_to_bcd_reader: RTL
======================

// Module: seg_to_bcd_reader
// PURPOSE
//  Decodes multiplexed 7-segment drive lines (a..g,dp) back to BCD digits, the
//  inverse of our BCD-to-7-segment encoder. Sits on a scanned display bus
//  (one-hot digit strobe plus shared segment lines), qualifies each digit by
//  stability, assembles a full frame and hands it off with valid/ready.
// PARAMETERS
//  DIGITS         4  number of scanned digits (strobe width), >=1
//  STABLE_CYCLES  3  consecutive identical samples required to capture a digit, >=1
//  COMMON_ANODE   0  1: seg inputs are active-low and are inverted before decode
// PORTS
//  clk        in   1          system clock, rising edge
//  rst_n      in   1          asynchronous active-low reset
//  seg        in   8          segment lines {a,b,c,d,e,f,g,dp}, a = bit7
//  dig_sel    in   DIGITS     digit strobe, active-high, one-hot when valid
//  bcd        out  4*DIGITS   frame digits, digit i at [4i+3:4i]
//  dp_out     out  DIGITS     decimal-point state per digit
//  err        out  DIGITS     1 = digit i held an undecodable pattern
//  out_valid  out  1          frame available
//  out_ready  in   1          consumer accepts frame
//  overrun    out  1          1-cycle pulse: capture dropped while frame pending
// BEHAVIOUR
//  Reset: bcd, dp_out, err, capture mask, stability counter, out_valid and
//   overrun all 0; no input samples retained.
//  Input polarity: p = COMMON_ANODE ? ~seg : seg. Decode uses p[7:1] only.
//   dp is taken directly from p[0].
//  Decode table, p[7:1] -> code: 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6,
//   70->7, 7F->8, 73->9. Any other value, including blank 00, gives code
//   4'hF with err=1.
//  Stability tracking, evaluated every clock:
//   - A sample qualifies only when dig_sel has exactly one bit set. If dig_sel
//     is zero or multi-hot, the counter clears and the armed flag clears.
//   - On a qualifying sample with the same dig_sel and same p as the previous
//     cycle, the counter increments and saturates at STABLE_CYCLES. Otherwise
//     the counter loads 1 and the armed flag sets.
//   - The counter reaching STABLE_CYCLES while armed triggers a capture and
//     clears armed. Exactly one capture occurs per stable dwell, even if the
//     dwell continues. STABLE_CYCLES=1 captures on the first qualifying sample.
//  Capture (out_valid=0): writes bcd/dp_out/err for the strobed digit at that
//   clock edge and sets the digit's mask bit. Recapture of an already-masked
//   digit overwrites it; the newest value wins.
//  Frame completion: when the mask is all ones at the end of an edge, out_valid
//   rises on the next edge. The mask clears on that same edge.
//  Handoff: bcd/dp_out/err are held stable while out_valid=1. The transfer
//   occurs on a clock where out_valid & out_ready, and out_valid drops on the
//   next edge. out_ready is ignored while out_valid=0, and there is no
//   combinational path from out_ready to any output.
//  Capture while out_valid=1: the capture is dropped, the mask is unchanged,
//   and overrun pulses high for 1 cycle.
//  Capture on the handshake cycle: that capture is also dropped, with overrun
//   pulsing (frame registers are frozen).
//  Async reset mid-frame or mid-handshake: all state is cleared immediately and
//   a partially captured frame is discarded.
//  Latency: the last digit's first stable sample at edge k produces out_valid
//   high after edge k+STABLE_CYCLES.
// TESTING
//  1. Defaults, COMMON_ANODE=0. Strobe digits 0..3 for 4 cycles each with
//     seg=FC,60,DA,F2 -> out_valid=1, bcd=16'h3210, err=0, dp_out=0.
//  2. Pattern changes mid-dwell on digit 1: seg=B6 x2 cycles, then BE x3 ->
//     digit1=6. A dwell of only 2 identical cycles never captures.
//  3. Digit 2 with seg=00, then seg=E7 -> digit 2 code F with err[2]=1. Digit 3
//     with seg=E7 -> code 9 with dp_out[3]=1.
//  4. Hold out_ready=0 and complete a second scan -> overrun pulses once per
//     dropped capture, and the frame stays at its first values. Raise
//     out_ready -> out_valid=0 on the next cycle.
//  5. dig_sel=4'b0011 for 5 cycles -> no capture. Deassert rst_n mid-frame
//     (2 digits captured) -> outputs 0, and a full new scan is needed before
//     out_valid.
//  6. COMMON_ANODE=1 with seg=~8'hFE on all digits -> bcd=16'h8888.

Source files
------------

// File: rtl/seg_to_bcd_reader.sv
// Scanned 7-segment bus reader: qualifies each strobed digit by stability,
// decodes it back to BCD and hands complete frames off with valid/ready.
module seg_to_bcd_reader #(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned STABLE_CYCLES = 3,
    parameter bit          COMMON_ANODE  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            seg,
    input  logic [DIGITS-1:0]     dig_sel,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     dp_out,
    output logic [DIGITS-1:0]     err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overrun
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [DIGITS-1:0]     sel_prev_q;
    logic [7:0]            p_prev_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  armed_q, armed_d;
    logic [DIGITS-1:0]     mask_q, mask_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic [DIGITS-1:0]     dp_q, dp_d;
    logic [DIGITS-1:0]     err_q, err_d;
    logic                  overrun_q, overrun_d;

    logic [7:0]            p_c;
    logic                  sel_onehot_c;
    logic                  same_c;
    logic                  armed_new_c;
    logic                  capture_c;
    logic [3:0]            dec_code_c;
    logic                  dec_err_c;

    // Segment pattern {a..g} to {err, code}; anything unrecognised is 4'hF.
    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'h7E:   r = 5'h00;
            7'h30:   r = 5'h01;
            7'h6D:   r = 5'h02;
            7'h79:   r = 5'h03;
            7'h33:   r = 5'h04;
            7'h5B:   r = 5'h05;
            7'h5F:   r = 5'h06;
            7'h70:   r = 5'h07;
            7'h7F:   r = 5'h08;
            7'h73:   r = 5'h09;
            default: r = 5'h1F;
        endcase
        return r;
    endfunction

    assign p_c = COMMON_ANODE ? ~seg : seg;
    assign {dec_err_c, dec_code_c} = decode(p_c[7:1]);
    assign sel_onehot_c = $onehot(dig_sel);
    assign same_c = (dig_sel == sel_prev_q) && (p_c == p_prev_q);

    // Dwell tracking: one capture per run of identical one-hot samples.
    always_comb begin
        cnt_d       = '0;
        armed_d     = 1'b0;
        armed_new_c = 1'b0;
        capture_c   = 1'b0;
        if (sel_onehot_c) begin
            if (same_c) begin
                cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : CNT_W'(cnt_q + CNT_ONE);
                armed_new_c = armed_q;
            end else begin
                cnt_d       = CNT_ONE;
                armed_new_c = 1'b1;
            end
            capture_c = armed_new_c && (cnt_d == CNT_MAX);
            armed_d   = armed_new_c && !capture_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_prev_q <= '0;
            p_prev_q   <= '0;
            cnt_q      <= '0;
            armed_q    <= 1'b0;
        end else begin
            sel_prev_q <= dig_sel;
            p_prev_q   <= p_c;
            cnt_q      <= cnt_d;
            armed_q    <= armed_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame assembly and handoff; frame registers freeze while a frame is held.
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        bcd_d     = bcd_q;
        dp_d      = dp_q;
        err_d     = err_q;
        overrun_d = 1'b0;
        case (state_q)
            ST_COLLECT: begin
                if (capture_c) begin
                    for (int unsigned i = 0; i < DIGITS; i++) begin
                        if (dig_sel[i]) begin
                            bcd_d[4*i +: 4] = dec_code_c;
                            dp_d[i]         = p_c[0];
                            err_d[i]        = dec_err_c;
                            mask_d[i]       = 1'b1;
                        end
                    end
                end
                if (&mask_q) begin
                    state_d = ST_HOLD;
                    mask_d  = '0;
                end
            end
            ST_HOLD: begin
                overrun_d = capture_c;
                if (out_ready) begin
                    state_d = ST_COLLECT;
                end
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q    <= '0;
            bcd_q     <= '0;
            dp_q      <= '0;
            err_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            mask_q    <= mask_d;
            bcd_q     <= bcd_d;
            dp_q      <= dp_d;
            err_q     <= err_d;
            overrun_q <= overrun_d;
        end
    end

    assign bcd       = bcd_q;
    assign dp_out    = dp_q;
    assign err       = err_q;
    assign overrun   = overrun_q;
    assign out_valid = (state_q == ST_HOLD);

endmodule
